// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue path.
// Op encodings, issuer state encoding and op-class helpers.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_READ  = 3'b001;
  localparam logic [2:0] MD_MTLO  = 3'b010;
  localparam logic [2:0] MD_MTHI  = 3'b011;
  localparam logic [2:0] MD_DIV   = 3'b100;
  localparam logic [2:0] MD_DIVU  = 3'b101;
  localparam logic [2:0] MD_MULT  = 3'b110;
  localparam logic [2:0] MD_MULTU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } md_state_t;

  function automatic logic is_md_arith(
    input logic [2:0] op
  );
    return op[2];
  endfunction

  function automatic logic is_md_write(
    input logic [2:0] op
  );
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// E-stage issuer for the HI/LO multiply/divide unit.
// Issues ops, tracks the in-flight op and stalls on hazards.
import md_pkg::*;

module md_issue_ctrl #(
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [2:0]    op_code,
  input  logic          op_sel_hi,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic          flush,
  input  logic          xalu_busy,
  input  logic [DW-1:0] xalu_hi,
  input  logic [DW-1:0] xalu_lo,
  output logic [2:0]    xalu_op,
  output logic [DW-1:0] xalu_a,
  output logic [DW-1:0] xalu_b,
  output logic          stall,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          timeout_err
);

  md_state_t        state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             op_live;
  logic             accept;

  assign op_live = op_valid
                && (op_code != MD_NONE)
                && !flush;
  assign stall   = op_live
                && ((state != IDLE) || xalu_busy);
  assign accept  = op_live && !stall;

  // A flush in the ISSUE cycle keeps the op away from the unit.
  assign xalu_op = (state == ISSUE && !flush)
                 ? op_q : MD_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= MD_NONE;
      xalu_a      <= '0;
      xalu_b      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (op_code == MD_READ) begin
              rd_data  <= op_sel_hi ? xalu_hi
                                    : xalu_lo;
              rd_valid <= 1'b1;
            end else begin
              op_q   <= op_code;
              xalu_a <= op_a;
              xalu_b <= op_b;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush || is_md_write(op_q)) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (!xalu_busy) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Give up tracking; the unit itself keeps running.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl with a behavioural mul/div unit and busy stub.
// Expected HI/LO values come from a plain arithmetic model of the ISA.
import md_pkg::*;

module tb_md_issue_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic [2:0]    op_code;
  logic          op_sel_hi;
  logic [DW-1:0] op_a, op_b;
  logic          flush;
  logic          xalu_busy;
  logic [DW-1:0] xalu_hi, xalu_lo;
  logic [2:0]    xalu_op;
  logic [DW-1:0] xalu_a, xalu_b;
  logic          stall;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          timeout_err;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] m_hi, m_lo;

  logic          force_busy, never_busy;
  logic          u_busy;
  int            u_cnt;
  logic [63:0]   u_res;

  always #5 clk = ~clk;

  md_issue_ctrl #(
    .DW(DW), .TIMEOUT_CYC(15), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code),
    .op_sel_hi(op_sel_hi),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .xalu_busy(xalu_busy),
    .xalu_hi(xalu_hi), .xalu_lo(xalu_lo),
    .xalu_op(xalu_op),
    .xalu_a(xalu_a), .xalu_b(xalu_b),
    .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid),
    .timeout_err(timeout_err)
  );

  // Architectural result {HI, LO} of an arithmetic op.
  function automatic logic [63:0] calc(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sb, q, r;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    sa = a;
    sb = b;
    case (op)
      MD_MULT:  return pa * pb;
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Behavioural multiply/divide unit with random latency.
  always @(posedge clk) begin
    if (reset) begin
      xalu_hi <= '0;
      xalu_lo <= '0;
      u_busy  <= 1'b0;
      u_cnt   <= 0;
      u_res   <= '0;
    end else if (u_busy) begin
      if (u_cnt <= 1) begin
        u_busy <= 1'b0;
        {xalu_hi, xalu_lo} <= u_res;
      end
      u_cnt <= u_cnt - 1;
    end else if (xalu_op == MD_MTLO) begin
      xalu_lo <= xalu_a;
    end else if (xalu_op == MD_MTHI) begin
      xalu_hi <= xalu_a;
    end else if (xalu_op[2]) begin
      if (never_busy) begin
        {xalu_hi, xalu_lo} <= calc(xalu_op, xalu_a, xalu_b);
      end else begin
        u_res  <= calc(xalu_op, xalu_a, xalu_b);
        u_busy <= 1'b1;
        u_cnt  <= int'($urandom_range(1, 6));
      end
    end
  end

  assign xalu_busy = u_busy | force_busy;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present_wait(output int stalls);
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
  endtask

  // Returns in the ISSUE cycle, with flush driven to fl.
  task automatic issue(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic fl,
    output int stalls
  );
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    present_wait(stalls);
    cyc();
    op_valid = 1'b0;
    op_code  = MD_NONE;
    flush    = fl;
  endtask

  task automatic do_read(
    input logic hi,
    output logic [31:0] data,
    output logic vld,
    output logic vld_after,
    output int stalls
  );
    op_valid  = 1'b1;
    op_code   = MD_READ;
    op_sel_hi = hi;
    present_wait(stalls);
    cyc();
    op_valid = 1'b0;
    op_code  = MD_NONE;
    @(negedge clk);
    vld  = rd_valid;
    data = rd_data;
    cyc();
    @(negedge clk);
    vld_after = rd_valid;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v, va;
    int s;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({xalu_op, xalu_a, xalu_b, rd_data,
         rd_valid, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs op=%b a=%h b=%h rd=%h v=%b to=%b want 0",
               xalu_op, xalu_a, xalu_b, rd_data,
               rd_valid, timeout_err);
    end
    cyc();
    do_read(1'b0, d, v, va, s);
    total++;
    if (s !== 0 || d !== 32'h0 || v !== 1'b1) begin
      bad++;
      $display("FAIL reset_read stalls=%0d d=%h v=%b want 0/0/1",
               s, d, v);
    end
  endtask

  task automatic test_multu();
    logic [31:0] d;
    logic v, va;
    int s;
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, s);
    {m_hi, m_lo} = 64'h1_0000_0000;
    @(negedge clk);
    total++;
    if (s !== 0 || xalu_op !== MD_MULTU ||
        xalu_a !== 32'h0001_0000 ||
        xalu_b !== 32'h0001_0000) begin
      bad++;
      $display("FAIL multu_issue s=%0d op=%b a=%h b=%h want 0/111/10000/10000",
               s, xalu_op, xalu_a, xalu_b);
    end
    cyc();
    @(negedge clk);
    total++;
    if (xalu_op !== MD_NONE) begin
      bad++;
      $display("FAIL multu_op_pulse op=%b want 000", xalu_op);
    end
    cyc();
    do_read(1'b1, d, v, va, s);
    total++;
    if (s < 1 || s >= 100 || d !== 32'h1 ||
        v !== 1'b1 || va !== 1'b0) begin
      bad++;
      $display("FAIL multu_mfhi stalls=%0d d=%h v=%b va=%b want >=1/1/1/0",
               s, d, v, va);
    end
    do_read(1'b0, d, v, va, s);
    total++;
    if (s !== 0 || d !== 32'h0 || v !== 1'b1) begin
      bad++;
      $display("FAIL multu_mflo stalls=%0d d=%h v=%b want 0/0/1",
               s, d, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v, va;
    int s;
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0, s);
    m_hi = 32'hDEAD_BEEF;
    do_read(1'b1, d, v, va, s);
    total++;
    if (s !== 1 || d !== 32'hDEAD_BEEF ||
        v !== 1'b1 || va !== 1'b0) begin
      bad++;
      $display("FAIL b2b_mfhi stalls=%0d d=%h v=%b va=%b want 1/deadbeef/1/0",
               s, d, v, va);
    end
  endtask

  task automatic test_flush_issue();
    logic [31:0] d;
    logic v, va;
    int s;
    issue(MD_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0, s);
    m_lo = 32'hCAFE_F00D;
    cyc();
    issue(MD_MTLO, 32'h1234_5678, 32'h0, 1'b1, s);
    @(negedge clk);
    total++;
    if (xalu_op !== MD_NONE) begin
      bad++;
      $display("FAIL flush_op op=%b want 000", xalu_op);
    end
    cyc();
    flush = 1'b0;
    do_read(1'b0, d, v, va, s);
    total++;
    if (s !== 0 || d !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL flush_old_lo stalls=%0d d=%h want 0/cafef00d",
               s, d);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic v, va;
    int s, k;
    issue(MD_MULT, 32'd7, 32'd6, 1'b0, s);
    {m_hi, m_lo} = 64'd42;
    force_busy = 1'b1;
    k = 0;
    @(negedge clk);
    while (!timeout_err && k < 40) begin
      k++;
      @(negedge clk);
    end
    total++;
    if (k !== 16) begin
      bad++;
      $display("FAIL timeout_cycles got=%0d want 16", k);
    end
    cyc();
    force_busy = 1'b0;
    do_read(1'b0, d, v, va, s);
    total++;
    if (s !== 0 || d !== 32'd42) begin
      bad++;
      $display("FAIL timeout_idle stalls=%0d d=%h want 0/2a",
               s, d);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky got=%b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] d;
    logic v, va;
    int s;
    issue(MD_DIVU, 32'd1000, 32'd3, 1'b0, s);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    total++;
    if ({xalu_op, xalu_a, xalu_b, rd_data,
         rd_valid, timeout_err, stall} !== '0) begin
      bad++;
      $display("FAIL rst_wait op=%b a=%h b=%h rd=%h v=%b to=%b st=%b want 0",
               xalu_op, xalu_a, xalu_b, rd_data,
               rd_valid, timeout_err, stall);
    end
    cyc();
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, s);
    {m_hi, m_lo} = 64'hFFFF_FFFF_FFFF_FFF1;
    @(negedge clk);
    total++;
    if (s !== 0 || xalu_op !== MD_MULT) begin
      bad++;
      $display("FAIL rst_new_mult s=%0d op=%b want 0/110",
               s, xalu_op);
    end
    cyc();
    do_read(1'b0, d, v, va, s);
    total++;
    if (d !== m_lo || s >= 100) begin
      bad++;
      $display("FAIL rst_mult_lo d=%h want %h stalls=%0d",
               d, m_lo, s);
    end
  endtask

  task automatic test_no_busy();
    logic [31:0] d;
    logic v, va;
    int s;
    never_busy = 1'b1;
    issue(MD_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, s);
    {m_hi, m_lo} = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
    @(negedge clk);
    total++;
    if (xalu_op !== MD_DIV) begin
      bad++;
      $display("FAIL nobusy_op op=%b want 100", xalu_op);
    end
    cyc();
    op_valid  = 1'b1;
    op_code   = MD_READ;
    op_sel_hi = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL nobusy_wait stall=%b want 1", stall);
    end
    cyc();
    do_read(1'b0, d, v, va, s);
    total++;
    if (s !== 0 || d !== 32'hFFFF_FFF2 ||
        timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL nobusy_mflo stalls=%0d d=%h to=%b want 0/fffffff2/0",
               s, d, timeout_err);
    end
    never_busy = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] d, a, b, want;
    logic v, va, hi, fl;
    logic [2:0] op;
    int s;
    int unsigned r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        hi = 1'($urandom_range(0, 1));
        want = hi ? m_hi : m_lo;
        do_read(hi, d, v, va, s);
        total++;
        if (d !== want || v !== 1'b1 ||
            va !== 1'b0 || s >= 100) begin
          bad++;
          $display("FAIL rnd_read i=%0d hi=%b d=%h want %h v=%b va=%b s=%0d",
                   i, hi, d, want, v, va, s);
        end
      end else begin
        if (r < 6)
          op = 3'(2 + $urandom_range(0, 1));
        else
          op = 3'(4 + $urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        if (b == 0) b = 32'd1;
        if (op == MD_DIV && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) b = 32'd1;
        fl = ($urandom_range(0, 7) == 0);
        issue(op, a, b, fl, s);
        @(negedge clk);
        total++;
        if (xalu_op !== (fl ? MD_NONE : op) || s >= 100) begin
          bad++;
          $display("FAIL rnd_issue i=%0d op=%b want %b s=%0d",
                   i, xalu_op, fl ? MD_NONE : op, s);
        end
        if (!fl) begin
          if (op == MD_MTLO) m_lo = a;
          else if (op == MD_MTHI) m_hi = a;
          else {m_hi, m_lo} = calc(op, a, b);
        end
        cyc();
        flush = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    op_valid   = 1'b0;
    op_code    = MD_NONE;
    op_sel_hi  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    flush      = 1'b0;
    force_busy = 1'b0;
    never_busy = 1'b0;
    m_hi       = '0;
    m_lo       = '0;
    test_reset();
    test_multu();
    test_back_to_back();
    test_flush_issue();
    test_timeout();
    test_reset_wait();
    test_no_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
